dmem_arbiter: RTL
=================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: consecutive denied DMA cycles before DMA is forced to win (range 1..15).
REQ-002 SHALL have parameter LOCK_MAX, default 8: maximum consecutive locked DMA grant cycles (range 1..15).
REQ-003 Ports SHALL be exactly as follows; one clock clk, reset clrn asynchronous active-low:
- clk  in  1  clock, all state on rising edge
- clrn  in  1  asynchronous active-low reset
- cpu_req  in  1  CPU memory access request
- cpu_we  in  1  CPU store
- cpu_addr  in  32  CPU byte address
- cpu_wdata  in  32  CPU store data
- cpu_rdata  out  32  CPU load data
- cpu_stall  out  1  hold CPU MEM stage this cycle
- dma_req  in  1  DMA access request
- dma_we  in  1  DMA write
- dma_lock  in  1  DMA requests ownership past this access
- dma_addr  in  32  DMA byte address
- dma_wdata  in  32  DMA write data
- dma_rdata  out  32  DMA read data
- dma_gnt  out  1  DMA access performed this cycle
- mem_addr  out  32  to data memory addr
- mem_datain  out  32  to data memory datain
- mem_we  out  1  to data memory we
- mem_dataout  in  32  from data memory, combinational read

Function
REQ-004 Memory read is combinational and the write commits at posedge, so each granted access SHALL complete in the same cycle (zero added latency).
REQ-005 Exactly one requester SHALL own the memory port per cycle; mem_addr/mem_datain/mem_we SHALL be muxed from the owner; mem_we SHALL be 0 with no owner.
REQ-006 cpu_rdata and dma_rdata SHALL both be driven with mem_dataout; each is valid only in that requester's granted cycle.
REQ-007 cpu_stall SHALL be cpu_req AND NOT cpu-granted; dma_gnt SHALL be dma_req AND dma-granted.
REQ-008 FSM states SHALL be IDLE, CPU, DMA, DMA_LOCK; the state records the previous cycle's owner.
REQ-009 Grant without contention: sole requester wins.
REQ-010 Contention, default policy: CPU wins unless starve_cnt == STARVE_LIMIT or state == DMA_LOCK.
REQ-011 starve_cnt (4 bits) SHALL increment on each cycle DMA is denied while requesting, clear on any DMA grant or cycle with dma_req low, and saturate at STARVE_LIMIT.
REQ-012 Entering DMA_LOCK: DMA granted with dma_lock high; remain while dma_req and dma_lock stay high; lock_cnt counts locked grants.
REQ-013 When lock_cnt reaches LOCK_MAX and cpu_req is high, next cycle SHALL grant CPU, exit to CPU, and clear lock_cnt; without cpu_req the lock SHALL continue with lock_cnt held at LOCK_MAX.
REQ-014 dma_req dropping in DMA_LOCK SHALL release ownership the same cycle (cpu_req granted combinationally).
REQ-015 No requests: next state IDLE, counters cleared.

Reset
REQ-016 clrn low SHALL asynchronously force state IDLE, starve_cnt 0, lock_cnt 0, last_winner CPU.
REQ-017 While clrn low, mem_we, dma_gnt and cpu_stall SHALL be 0; mem_addr, mem_datain SHALL be 0.
REQ-018 Reset asserted mid-lock SHALL abandon the lock; no access is granted until the first edge after release.

Configuration
REQ-019 With DMEM_ARB_RR_EN defined, contention outside DMA_LOCK SHALL alternate grants via a last_winner register (loser of the last contended cycle wins), and starve_cnt SHALL be absent.
REQ-020 Without DMEM_ARB_RR_EN, REQ-010/REQ-011 fixed-CPU-priority-with-starvation policy SHALL apply; last_winner absent.

Structure
REQ-021 A shared package SHALL hold the state enum (IDLE, CPU, DMA, DMA_LOCK), the owner encoding, and counter width constant 4.
REQ-022 The grant decision SHALL be a sub-module dmem_arb_grant (combinational next-owner from requests, state, counters); the top holds registers and muxes.

Verification
REQ-023 CPU-only store: cpu_req=1, cpu_we=1, addr 0x50, data 0xA3 -> cpu_stall=0, mem_we=1 same cycle, next-cycle DMA read of 0x50 returns 0xA3.
REQ-024 Continuous contention, default build, STARVE_LIMIT=4 -> CPU granted 4 cycles, DMA on 5th, pattern repeats every 5 cycles; cpu_stall=1 only on DMA cycles.
REQ-025 DMA lock, LOCK_MAX=8, cpu_req held high -> 8 consecutive dma_gnt, then one CPU cycle, cpu_stall high exactly 8 cycles.
REQ-026 DMEM_ARB_RR_EN build, continuous contention -> grants alternate CPU, DMA, CPU, DMA starting with DMA after reset (last_winner CPU).
REQ-027 clrn pulsed low during DMA_LOCK while dma_we=1 -> mem_we=0 immediately, state IDLE, no memory word changes.
REQ-028 DMA drops dma_req in lock cycle 3 with cpu_req high -> CPU granted that same cycle, lock_cnt cleared.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: FSM states, owner encoding, counter width.
// Used by dmem_arbiter, dmem_arb_grant and dmem_arbiter_if.
package dmem_arbiter_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CPU      = 2'd1,
    DMA      = 2'd2,
    DMA_LOCK = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                input logic [CNT_W-1:0] lim);
    return (v >= lim) ? lim : CNT_W'(v + 1'b1);
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Request/decision bundle between the arbiter datapath and its grant logic.
// The master side presents qualified requests; the slave side returns the cycle's owner.
interface dmem_arbiter_if;
  import dmem_arbiter_pkg::*;

  logic   cpu_req;
  logic   dma_req;
  owner_t owner;

  modport master (output cpu_req, output dma_req, input owner);
  modport slave  (input cpu_req, input dma_req, output owner);

endinterface

// File: rtl/dmem_arb_grant.sv
// Combinational owner selection for the current cycle.
// Policy build option: DMEM_ARB_RR_EN selects round-robin contention instead of CPU priority with starvation.
module dmem_arb_grant
  import dmem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int LOCK_MAX     = 8
) (
  dmem_arbiter_if.slave    arb,
  input  state_t           state,
  input  logic [CNT_W-1:0] lock_cnt,
`ifdef DMEM_ARB_RR_EN
  input  owner_t           last_winner
`else
  input  logic [CNT_W-1:0] starve_cnt
`endif
);

  localparam logic [CNT_W-1:0] LOCK_C = CNT_W'(LOCK_MAX);
`ifndef DMEM_ARB_RR_EN
  localparam logic [CNT_W-1:0] STARVE_C = CNT_W'(STARVE_LIMIT);
`endif

  always_comb begin
    arb.owner = OWN_NONE;
    if (arb.cpu_req && !arb.dma_req) begin
      arb.owner = OWN_CPU;
    end else if (arb.dma_req && !arb.cpu_req) begin
      arb.owner = OWN_DMA;
    end else if (arb.cpu_req && arb.dma_req) begin
      if (state == DMA_LOCK) begin
        // A lock that has used its full budget yields exactly one cycle to the CPU.
        arb.owner = (lock_cnt == LOCK_C) ? OWN_CPU : OWN_DMA;
      end else begin
`ifdef DMEM_ARB_RR_EN
        arb.owner = (last_winner == OWN_CPU) ? OWN_DMA : OWN_CPU;
`else
        arb.owner = (starve_cnt == STARVE_C) ? OWN_DMA : OWN_CPU;
`endif
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// CPU/DMA arbiter for a single-port data memory with combinational read; grants complete same cycle.
// Build option DMEM_ARB_RR_EN: round-robin contention via last_winner instead of starvation counter.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int LOCK_MAX     = 8
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic        dma_lock,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic [31:0] dma_rdata,
  output logic        dma_gnt,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_datain,
  output logic        mem_we,
  input  logic [31:0] mem_dataout
);

  localparam logic [CNT_W-1:0] LOCK_C = CNT_W'(LOCK_MAX);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] lock_cnt_reg, lock_cnt_next;
  logic             run_reg;
`ifdef DMEM_ARB_RR_EN
  owner_t           last_winner_reg, last_winner_next;
`else
  localparam logic [CNT_W-1:0] STARVE_C = CNT_W'(STARVE_LIMIT);
  logic [CNT_W-1:0] starve_cnt_reg, starve_cnt_next;
`endif

  dmem_arbiter_if arb ();

  // Requests are masked in reset and until the first edge after release.
  assign arb.cpu_req = cpu_req & clrn & run_reg;
  assign arb.dma_req = dma_req & clrn & run_reg;

  dmem_arb_grant #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .LOCK_MAX     (LOCK_MAX)
  ) u_grant (
    .arb          (arb.slave),
    .state        (state_reg),
    .lock_cnt     (lock_cnt_reg),
`ifdef DMEM_ARB_RR_EN
    .last_winner  (last_winner_reg)
`else
    .starve_cnt   (starve_cnt_reg)
`endif
  );

  assign cpu_rdata = mem_dataout;
  assign dma_rdata = mem_dataout;
  assign dma_gnt   = arb.dma_req && (arb.owner == OWN_DMA);
  assign cpu_stall = cpu_req && clrn && (arb.owner != OWN_CPU);

  always_comb begin
    mem_addr   = '0;
    mem_datain = '0;
    mem_we     = 1'b0;
    case (arb.owner)
      OWN_CPU: begin
        mem_addr   = cpu_addr;
        mem_datain = cpu_wdata;
        mem_we     = cpu_we;
      end
      OWN_DMA: begin
        mem_addr   = dma_addr;
        mem_datain = dma_wdata;
        mem_we     = dma_we;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_next    = IDLE;
    lock_cnt_next = '0;
    case (arb.owner)
      OWN_CPU: state_next = CPU;
      OWN_DMA: begin
        if (dma_lock) begin
          state_next    = DMA_LOCK;
          // Held at LOCK_MAX while no CPU request forces the hand-back.
          lock_cnt_next = (state_reg == DMA_LOCK) ? sat_inc(lock_cnt_reg, LOCK_C)
                                                  : CNT_W'(1);
        end else begin
          state_next = DMA;
        end
      end
      default: state_next = IDLE;
    endcase
`ifdef DMEM_ARB_RR_EN
    last_winner_next = last_winner_reg;
    if (arb.cpu_req && arb.dma_req && (state_reg != DMA_LOCK))
      last_winner_next = arb.owner;
`else
    starve_cnt_next = '0;
    if (arb.dma_req && (arb.owner != OWN_DMA))
      starve_cnt_next = sat_inc(starve_cnt_reg, STARVE_C);
`endif
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_reg       <= IDLE;
      lock_cnt_reg    <= '0;
      run_reg         <= 1'b0;
`ifdef DMEM_ARB_RR_EN
      last_winner_reg <= OWN_CPU;
`else
      starve_cnt_reg  <= '0;
`endif
    end else begin
      state_reg       <= state_next;
      lock_cnt_reg    <= lock_cnt_next;
      run_reg         <= 1'b1;
`ifdef DMEM_ARB_RR_EN
      last_winner_reg <= last_winner_next;
`else
      starve_cnt_reg  <= starve_cnt_next;
`endif
    end
  end

endmodule
